// File: rtl/fft_scheduler.sv
// Address/twiddle sequencer for an in-place radix-2 DIT FFT with write-back delay line.
// Define FFT_SCHED_CHECK_EN to enable the sticky butterfly latency-mismatch flag (err).
module fft_scheduler #(
    parameter int LOG2N        = 3,
    parameter int BFLY_LATENCY = 1,
    localparam int SW          = $clog2(LOG2N + 1),
    localparam int KW          = LOG2N - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bfly_valid,
    output logic             bfly_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [KW-1:0]    tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [SW-1:0]    stage,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    logic [SW-1:0]    r_stage;
    logic [KW-1:0]    r_k;
    logic [3:0]       r_drain_cnt;
    logic [LOG2N-1:0] r_rd_a;
    logic [LOG2N-1:0] r_rd_b;
    logic [KW-1:0]    r_tw;

    logic             w_bfly_en;
    logic             w_wr_en;
    logic             w_last_k;
    logic             w_last_stage;
    logic [SW-1:0]    w_iss_stage;
    logic [KW-1:0]    w_iss_k;
    logic [LOG2N-1:0] w_iss_a;
    logic [LOG2N-1:0] w_iss_b;
    logic [KW-1:0]    w_iss_tw;

    function automatic logic [LOG2N-1:0] f_mask(input logic [SW-1:0] s);
        return (LOG2N'(1) << s) - LOG2N'(1);
    endfunction

    // grp*2*half + pos == (k with bits >= stage shifted up by one) | low bits of k
    function automatic logic [LOG2N-1:0] f_addr_a(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [LOG2N-1:0] k_ext;
        k_ext = {1'b0, k};
        return ((k_ext & ~f_mask(s)) << 1) | (k_ext & f_mask(s));
    endfunction

    function automatic logic [KW-1:0] f_tw(input logic [SW-1:0] s, input logic [KW-1:0] k);
        logic [LOG2N-1:0] pos;
        int               sh;
        pos = {1'b0, k} & f_mask(s);
        sh  = LOG2N - 1 - int'(s);
        return KW'(pos << sh);
    endfunction

    assign w_last_k     = (r_k == {KW{1'b1}});
    assign w_last_stage = (r_stage == SW'(LOG2N - 1));

    // Coordinates of the butterfly that would be issued in the next cycle
    always_comb begin
        w_iss_stage = r_stage;
        w_iss_k     = r_k + 1'b1;
        if (r_state == S_IDLE) begin
            w_iss_stage = '0;
            w_iss_k     = '0;
        end else if (r_state == S_DRAIN) begin
            w_iss_stage = r_stage + 1'b1;
            w_iss_k     = '0;
        end
        w_iss_a  = f_addr_a(w_iss_stage, w_iss_k);
        w_iss_b  = w_iss_a | (LOG2N'(1) << w_iss_stage);
        w_iss_tw = f_tw(w_iss_stage, w_iss_k);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_stage     <= '0;
            r_k         <= '0;
            r_drain_cnt <= '0;
            r_rd_a      <= '0;
            r_rd_b      <= '0;
            r_tw        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_stage <= w_iss_stage;
                        r_k     <= w_iss_k;
                        r_rd_a  <= w_iss_a;
                        r_rd_b  <= w_iss_b;
                        r_tw    <= w_iss_tw;
                    end
                end
                S_ISSUE: begin
                    if (w_last_k) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= 4'(BFLY_LATENCY - 1);
                        r_rd_a      <= '0;
                        r_rd_b      <= '0;
                        r_tw        <= '0;
                    end else begin
                        r_k    <= w_iss_k;
                        r_rd_a <= w_iss_a;
                        r_rd_b <= w_iss_b;
                        r_tw   <= w_iss_tw;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == 4'd0) begin
                        if (w_last_stage) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ISSUE;
                            r_stage <= w_iss_stage;
                            r_k     <= w_iss_k;
                            r_rd_a  <= w_iss_a;
                            r_rd_b  <= w_iss_b;
                            r_tw    <= w_iss_tw;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_stage <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_bfly_en = (r_state == S_ISSUE);
    assign bfly_en   = w_bfly_en;
    assign rd_addr_a = r_rd_a;
    assign rd_addr_b = r_rd_b;
    assign tw_idx    = r_tw;
    assign stage     = r_stage;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    // Write-back delay line; reset drops any in-flight butterflies
    logic             r_dl_en [BFLY_LATENCY];
    logic [LOG2N-1:0] r_dl_a  [BFLY_LATENCY];
    logic [LOG2N-1:0] r_dl_b  [BFLY_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                r_dl_en[i] <= 1'b0;
                r_dl_a[i]  <= '0;
                r_dl_b[i]  <= '0;
            end
        end else begin
            r_dl_en[0] <= w_bfly_en;
            r_dl_a[0]  <= r_rd_a;
            r_dl_b[0]  <= r_rd_b;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                r_dl_en[i] <= r_dl_en[i-1];
                r_dl_a[i]  <= r_dl_a[i-1];
                r_dl_b[i]  <= r_dl_b[i-1];
            end
        end
    end

    assign w_wr_en   = r_dl_en[BFLY_LATENCY-1];
    assign wr_en     = w_wr_en;
    assign wr_addr_a = r_dl_a[BFLY_LATENCY-1];
    assign wr_addr_b = r_dl_b[BFLY_LATENCY-1];

`ifdef FFT_SCHED_CHECK_EN
    logic r_err;
    logic w_mismatch;

    assign w_mismatch = bfly_valid ^ w_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_err <= 1'b0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
        end
    end

    // The mismatch is visible in the cycle it happens, then held by r_err
    assign err = ~rst & (r_err | w_mismatch);
`else
    logic w_unused;
    assign w_unused = bfly_valid;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_fft_scheduler.sv
// Directed self-checking bench for fft_scheduler: N=8 with latencies 1 and 3.
// The err checks follow FFT_SCHED_CHECK_EN when the bench is built with it.
module tb_fft_scheduler;

`ifdef FFT_SCHED_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk;
    logic       rst1, start1, valid1;
    logic       bfly_en1, wr_en1, busy1, done1, err1;
    logic [2:0] rd_a1, rd_b1, wr_a1, wr_b1;
    logic [1:0] tw1, stage1;

    logic       rst3, start3, valid3;
    logic       bfly_en3, wr_en3, busy3, done3, err3;
    logic [2:0] rd_a3, rd_b3, wr_a3, wr_b3;
    logic [1:0] tw3, stage3;

    int n_pass  = 0;
    int n_total = 0;

    // Hand-derived issue sequence for N=8: (a,b,tw) per butterfly, stage by stage
    int EA [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int EB [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int ET [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_scheduler #(.LOG2N(3), .BFLY_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .bfly_valid(valid1),
        .bfly_en(bfly_en1), .rd_addr_a(rd_a1), .rd_addr_b(rd_b1), .tw_idx(tw1),
        .wr_en(wr_en1), .wr_addr_a(wr_a1), .wr_addr_b(wr_b1), .stage(stage1),
        .busy(busy1), .done(done1), .err(err1)
    );

    fft_scheduler #(.LOG2N(3), .BFLY_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .start(start3), .bfly_valid(valid3),
        .bfly_en(bfly_en3), .rd_addr_a(rd_a3), .rd_addr_b(rd_b3), .tw_idx(tw3),
        .wr_en(wr_en3), .wr_addr_a(wr_a3), .wr_addr_b(wr_b3), .stage(stage3),
        .busy(busy3), .done(done3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", n_pass, n_total);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle c counts from the cycle in which start is sampled (cycle 0)
    function automatic bit is_iss(input int c, input int lat);
        int per;
        per = 4 + lat;
        if (c < 1 || c > 3 * per) return 1'b0;
        return ((c - 1) % per) < 4;
    endfunction

    function automatic int iss_idx(input int c, input int lat);
        return ((c - 1) / (4 + lat)) * 4 + (c - 1) % (4 + lat);
    endfunction

    // Full latency-1 pass, cycles 1..16; optional stray start pulses or held start
    task automatic pass1(input bit hold, input bit pulses);
        int j;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (!hold) start1 = pulses && (c == 3 || c == 5);
            valid1 = is_iss(c - 1, 1);
            #1;
            chk("p1_bfly_en", bfly_en1, is_iss(c, 1));
            chk("p1_wr_en", wr_en1, is_iss(c - 1, 1));
            chk("p1_done", done1, c == 16);
            chk("p1_busy", busy1, 1);
            chk("p1_err", err1, 0);
            if (is_iss(c, 1)) begin
                j = iss_idx(c, 1);
                chk("p1_rd_a", rd_a1, EA[j]);
                chk("p1_rd_b", rd_b1, EB[j]);
                chk("p1_tw", tw1, ET[j]);
                chk("p1_stage", stage1, j / 4);
            end
            if (is_iss(c - 1, 1)) begin
                j = iss_idx(c - 1, 1);
                chk("p1_wr_a", wr_a1, EA[j]);
                chk("p1_wr_b", wr_b1, EB[j]);
            end
        end
    endtask

    initial begin
        int j;
        rst1 = 1'b1; start1 = 1'b0; valid1 = 1'b0;
        rst3 = 1'b1; start3 = 1'b0; valid3 = 1'b0;
        #3;
        chk("rst_bfly_en", bfly_en1, 0);
        chk("rst_wr_en", wr_en1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_err", err1, 0);
        chk("rst_stage", stage1, 0);
        chk("rst_rd_b", rd_b1, 0);
        chk("rst_busy3", busy3, 0);
        tick(); tick();
        rst1 = 1'b0; rst3 = 1'b0;
        tick();
        chk("idle_busy", busy1, 0);

        // Basic full pass
        start1 = 1'b1;
        pass1(1'b0, 1'b0);
        tick();
        chk("after_busy", busy1, 0);
        chk("after_done", done1, 0);

        // Start pulses during ISSUE and DRAIN are ignored
        start1 = 1'b1;
        pass1(1'b0, 1'b1);
        tick();
        chk("pulse_after_busy", busy1, 0);

        // Start held high: back-to-back passes
        start1 = 1'b1;
        pass1(1'b1, 1'b0);
        tick();
        chk("hold_c17_bfly_en", bfly_en1, 0);
        chk("hold_c17_busy", busy1, 0);
        tick();
        start1 = 1'b0;
        chk("hold_c18_bfly_en", bfly_en1, 1);
        chk("hold_c18_rd_a", rd_a1, 0);
        chk("hold_c18_rd_b", rd_b1, 1);
        chk("hold_c18_tw", tw1, 0);
        for (int i = 0; i < 40 && busy1; i++) tick();
        chk("hold_second_pass_ends", busy1, 0);
        tick();

        // Reset in stage 1, k=2
        start1 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            start1 = 1'b0;
        end
        chk("mid_bfly_en", bfly_en1, 1);
        chk("mid_stage", stage1, 1);
        chk("mid_rd_a", rd_a1, 4);
        chk("mid_rd_b", rd_b1, 6);
        #2;
        rst1 = 1'b1;
        #1;
        chk("arst_bfly_en", bfly_en1, 0);
        chk("arst_wr_en", wr_en1, 0);
        chk("arst_busy", busy1, 0);
        chk("arst_stage", stage1, 0);
        chk("arst_rd_a", rd_a1, 0);
        chk("arst_rd_b", rd_b1, 0);
        chk("arst_tw", tw1, 0);
        chk("arst_wr_a", wr_a1, 0);
        chk("arst_err", err1, 0);
        tick(); tick();
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_wr", wr_en1, 0);
        end
        start1 = 1'b1;
        pass1(1'b0, 1'b0);
        tick();

        // Latency 3: writes trail issues by exactly 3 cycles, done in cycle 22
        start3 = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            start3 = 1'b0;
            chk("l3_bfly_en", bfly_en3, is_iss(c, 3));
            chk("l3_wr_en", wr_en3, is_iss(c - 3, 3));
            chk("l3_done", done3, c == 22);
            if (is_iss(c, 3)) begin
                j = iss_idx(c, 3);
                chk("l3_rd_a", rd_a3, EA[j]);
                chk("l3_tw", tw3, ET[j]);
            end
            if (is_iss(c - 3, 3)) begin
                j = iss_idx(c - 3, 3);
                chk("l3_wr_a", wr_a3, EA[j]);
                chk("l3_wr_b", wr_b3, EB[j]);
            end
        end
        tick();
        chk("l3_after_busy", busy3, 0);

        // bfly_valid one cycle late: err from the first mismatch, cleared by next start
        start1 = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start1 = 1'b0;
            valid1 = is_iss(c - 2, 1);
            #1;
            chk("late_err", err1, CHK && c >= 2);
        end
        tick();
        valid1 = 1'b0;
        #1;
        chk("late_err_held", err1, CHK);
        start1 = 1'b1;
        pass1(1'b0, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
